bht_predictor: RTL and testbench

Parametrised branch history table for the 5-stage pipeline, replacing the single global 2-bit predictor with a per-PC table of saturating counters. An optional gshare mode XORs a global history register into the index. Prediction is combinational from the ID-stage PC. Update comes from the EXE stage, using the table index the pipeline carried along with the branch. Built-in counters report resolved branches and mispredictions.

---
 rtl/bht_pkg.sv | 22 ++
 rtl/sat_counter.sv | 21 ++
 rtl/bht_predictor.sv | 107 ++++++++++
 tb/tb_bht_predictor.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/bht_pkg.sv
// Shared definitions for the branch history table predictor.
package bht_pkg;

  localparam int DEF_ENTRIES   = 64;
  localparam int DEF_CTR_BITS  = 2;
  localparam int DEF_HIST_BITS = 6;

  // Index scheme: plain PC bits, or PC bits XORed with global history.
  typedef enum logic {
    MODE_BIMODAL = 1'b0,
    MODE_GSHARE  = 1'b1
  } bht_mode_e;

  // Ceiling log2, usable in constant expressions (clog2(1) = 0).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up/down next-value logic for one table counter.
module sat_counter #(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] val_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [WIDTH-1:0] val_o
);

  // Step toward the outcome, holding at all-ones or zero.
  always_comb begin
    val_o = val_i;
    if (inc_i && (val_i != {WIDTH{1'b1}})) begin
      val_o = val_i + 1'b1;
    end else if (dec_i && (val_i != '0)) begin
      val_o = val_i - 1'b1;
    end
  end

endmodule

// File: rtl/bht_predictor.sv
// Per-PC table of saturating counters with optional gshare indexing.
// Prediction is combinational from the ID PC; the EXE stage returns the
// index it was given so updates need no re-hashing or flush recovery.
module bht_predictor
  import bht_pkg::*;
#(
  parameter int ENTRIES   = DEF_ENTRIES,
  parameter int CTR_BITS  = DEF_CTR_BITS,
  parameter int INIT      = 2 ** (CTR_BITS - 1),
  parameter int GSHARE    = 0,
  parameter int HIST_BITS = DEF_HIST_BITS,
  localparam int IDX_BITS = clog2(ENTRIES)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [31:0]          pc_i,
  output logic                 predict_o,
  output logic [IDX_BITS-1:0]  predict_idx_o,
  input  logic                 update_i,
  input  logic [IDX_BITS-1:0]  update_idx_i,
  input  logic                 update_taken_i,
  input  logic                 update_pred_i,
  output logic [HIST_BITS-1:0] ghr_o,
  output logic [31:0]          branch_cnt_o,
  output logic [31:0]          miss_cnt_o
);

  localparam bht_mode_e MODE = (GSHARE != 0) ? MODE_GSHARE : MODE_BIMODAL;

  logic [CTR_BITS-1:0]  ctr_q [ENTRIES];
  logic [CTR_BITS-1:0]  ctr_cur;
  logic [CTR_BITS-1:0]  ctr_d;
  logic [HIST_BITS-1:0] ghr_q;
  logic [HIST_BITS-1:0] ghr_d;
  logic [31:0]          branch_cnt_q;
  logic [31:0]          miss_cnt_q;
  logic [IDX_BITS-1:0]  pc_idx;
  logic [IDX_BITS-1:0]  hist_idx;
  logic [IDX_BITS-1:0]  pred_idx;
  logic                 unused_pc;

  // Only the word-aligned index bits of the PC select an entry.
  assign unused_pc = ^{pc_i[31:IDX_BITS+2], pc_i[1:0]};

  // Table index from the ID PC, folding in history in gshare mode.
  always_comb begin
    pc_idx   = pc_i[IDX_BITS+1:2];
    hist_idx = '0;
    if (MODE == MODE_GSHARE) begin
      hist_idx = IDX_BITS'(ghr_q);
    end
    pred_idx = pc_idx ^ hist_idx;
  end

  assign predict_idx_o = pred_idx;
  assign predict_o     = ctr_q[pred_idx][CTR_BITS-1];
  assign ghr_o         = (MODE == MODE_GSHARE) ? ghr_q : '0;
  assign branch_cnt_o  = branch_cnt_q;
  assign miss_cnt_o    = miss_cnt_q;

  assign ctr_cur = ctr_q[update_idx_i];

  sat_counter #(
    .WIDTH (CTR_BITS)
  ) u_sat (
    .val_i (ctr_cur),
    .inc_i (update_taken_i),
    .dec_i (~update_taken_i),
    .val_o (ctr_d)
  );

  // Shift the resolved outcome into the history; a 1-bit history is just it.
  if (HIST_BITS == 1) begin : g_ghr_one
    assign ghr_d = update_taken_i;
  end else begin : g_ghr_shift
    assign ghr_d = {ghr_q[HIST_BITS-2:0], update_taken_i};
  end

  // Counter table write; reset wins over a simultaneous update.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= CTR_BITS'(INIT);
      end
    end else if (update_i) begin
      ctr_q[update_idx_i] <= ctr_d;
    end
  end

  // Non-speculative history and resolution statistics.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ghr_q        <= '0;
      branch_cnt_q <= '0;
      miss_cnt_q   <= '0;
    end else if (update_i) begin
      if (MODE == MODE_GSHARE) begin
        ghr_q <= ghr_d;
      end
      branch_cnt_q <= branch_cnt_q + 32'd1;
      if (update_pred_i != update_taken_i) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_bht_predictor.sv
// Directed checks of the bimodal and gshare configurations.
module tb_bht_predictor;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] pc_i;
  logic        update_i;
  logic [5:0]  update_idx_i;
  logic        update_taken_i;
  logic        update_pred_i;

  logic        b_predict, g_predict;
  logic [5:0]  b_idx, g_idx;
  logic [5:0]  b_ghr;
  logic [3:0]  g_ghr;
  logic [31:0] b_branch, b_miss, g_branch, g_miss;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  bht_predictor #(.ENTRIES(64), .CTR_BITS(2), .GSHARE(0), .HIST_BITS(6)) dut_b (
    .clk_i(clk_i), .rst_i(rst_i), .pc_i(pc_i),
    .predict_o(b_predict), .predict_idx_o(b_idx),
    .update_i(update_i), .update_idx_i(update_idx_i),
    .update_taken_i(update_taken_i), .update_pred_i(update_pred_i),
    .ghr_o(b_ghr), .branch_cnt_o(b_branch), .miss_cnt_o(b_miss)
  );

  bht_predictor #(.ENTRIES(64), .CTR_BITS(2), .GSHARE(1), .HIST_BITS(4)) dut_g (
    .clk_i(clk_i), .rst_i(rst_i), .pc_i(pc_i),
    .predict_o(g_predict), .predict_idx_o(g_idx),
    .update_i(update_i), .update_idx_i(update_idx_i),
    .update_taken_i(update_taken_i), .update_pred_i(update_pred_i),
    .ghr_o(g_ghr), .branch_cnt_o(g_branch), .miss_cnt_o(g_miss)
  );

  typedef struct {
    logic        upd;
    logic [5:0]  idx;
    logic        taken;
    logic        pred;
    logic [31:0] pc;
    logic        exp_pred;
    logic [5:0]  exp_idx;
    logic [31:0] exp_br;
    logic [31:0] exp_miss;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic upd, input logic [5:0] idx, input logic taken,
                       input logic pred, input logic [31:0] pc);
    update_i       = upd;
    update_idx_i   = idx;
    update_taken_i = taken;
    update_pred_i  = pred;
    pc_i           = pc;
  endtask

  // One clock with the given update, then idle inputs sampled away from the edge.
  task automatic step(input logic upd, input logic [5:0] idx, input logic taken,
                      input logic pred, input logic [31:0] pc);
    @(negedge clk_i);
    drive(upd, idx, taken, pred, pc);
    @(posedge clk_i);
    #1;
    update_i = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    drive(1'b0, 6'd0, 1'b0, 1'b0, 32'h0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b0;
    drive(1'b0, 6'd0, 1'b0, 1'b0, 32'h0);

    //          upd idx   tk  pr  pc            pred idx   br     miss
    vecs[0]  = '{1'b0, 6'd0, 1'b0, 1'b0, 32'h0000_0040, 1'b1, 6'd16, 32'd0,  32'd0};
    vecs[1]  = '{1'b1, 6'd5, 1'b0, 1'b1, 32'h0000_0014, 1'b1, 6'd5,  32'd1,  32'd1};
    vecs[2]  = '{1'b1, 6'd5, 1'b0, 1'b0, 32'h0000_0014, 1'b0, 6'd5,  32'd2,  32'd1};
    vecs[3]  = '{1'b1, 6'd5, 1'b0, 1'b0, 32'h0000_0014, 1'b0, 6'd5,  32'd3,  32'd1};
    vecs[4]  = '{1'b1, 6'd5, 1'b0, 1'b0, 32'h0000_0014, 1'b0, 6'd5,  32'd4,  32'd1};
    vecs[5]  = '{1'b1, 6'd5, 1'b1, 1'b0, 32'h0000_0014, 1'b0, 6'd5,  32'd5,  32'd2};
    vecs[6]  = '{1'b1, 6'd5, 1'b1, 1'b0, 32'h0000_0014, 1'b0, 6'd5,  32'd6,  32'd3};
    vecs[7]  = '{1'b0, 6'd0, 1'b0, 1'b0, 32'hABCD_0114, 1'b1, 6'd5,  32'd6,  32'd3};
    vecs[8]  = '{1'b1, 6'd3, 1'b0, 1'b1, 32'h0000_000C, 1'b1, 6'd3,  32'd7,  32'd4};
    vecs[9]  = '{1'b1, 6'd3, 1'b1, 1'b0, 32'h0000_000C, 1'b0, 6'd3,  32'd8,  32'd5};
    vecs[10] = '{1'b0, 6'd0, 1'b0, 1'b0, 32'h0000_000C, 1'b1, 6'd3,  32'd8,  32'd5};
    vecs[11] = '{1'b1, 6'd9, 1'b1, 1'b1, 32'h0000_0024, 1'b1, 6'd9,  32'd9,  32'd5};
    vecs[12] = '{1'b1, 6'd9, 1'b1, 1'b1, 32'h0000_0024, 1'b1, 6'd9,  32'd10, 32'd5};
    vecs[13] = '{1'b1, 6'd9, 1'b0, 1'b1, 32'h0000_0024, 1'b1, 6'd9,  32'd11, 32'd6};
    vecs[14] = '{1'b1, 6'd9, 1'b0, 1'b1, 32'h0000_0024, 1'b1, 6'd9,  32'd12, 32'd7};
    vecs[15] = '{1'b0, 6'd0, 1'b0, 1'b0, 32'h0000_0024, 1'b0, 6'd9,  32'd12, 32'd7};

    do_reset();
    check("reset_ghr_gshare", 32'(g_ghr), 32'd0);
    check("reset_miss_gshare", g_miss, 32'd0);

    // Bimodal table: predict shown before the edge, stats after it.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_i);
      drive(vecs[i].upd, vecs[i].idx, vecs[i].taken, vecs[i].pred, vecs[i].pc);
      #1;
      check($sformatf("vec%0d_predict", i), 32'(b_predict), 32'(vecs[i].exp_pred));
      check($sformatf("vec%0d_idx", i), 32'(b_idx), 32'(vecs[i].exp_idx));
      @(posedge clk_i);
      #1;
      check($sformatf("vec%0d_branch", i), b_branch, vecs[i].exp_br);
      check($sformatf("vec%0d_miss", i), b_miss, vecs[i].exp_miss);
    end
    check("bimodal_ghr_zero", 32'(b_ghr), 32'd0);

    // Gshare history T,T,N,T; last update cycle must still index with 0110.
    do_reset();
    step(1'b1, 6'd0, 1'b1, 1'b1, 32'h0);
    step(1'b1, 6'd0, 1'b1, 1'b1, 32'h0);
    step(1'b1, 6'd0, 1'b0, 1'b1, 32'h0);
    @(negedge clk_i);
    drive(1'b1, 6'd0, 1'b1, 1'b1, 32'h0000_0020);
    #1;
    check("gshare_idx_preupdate", 32'(g_idx), 32'd14);
    @(posedge clk_i);
    #1;
    update_i = 1'b0;
    check("gshare_ghr", 32'(g_ghr), 32'b1101);
    check("gshare_idx", 32'(g_idx), 32'd5);
    check("gshare_predict_init", 32'(g_predict), 32'd1);

    // Ten resolutions, four mispredicted.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      logic miss;
      miss = (i == 1) || (i == 4) || (i == 6) || (i == 9);
      step(1'b1, 6'(i + 20), i[0], i[0] ^ miss, 32'h0);
    end
    check("stats_branch10", b_branch, 32'd10);
    check("stats_miss4", b_miss, 32'd4);

    // Branch counter wraps.
    @(negedge clk_i);
    force dut_b.branch_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut_b.branch_cnt_q;
    drive(1'b1, 6'd30, 1'b1, 1'b1, 32'h0);
    @(posedge clk_i);
    #1;
    update_i = 1'b0;
    check("branch_wrap", b_branch, 32'd0);

    // Reset overrides a simultaneous taken update to idx 7.
    do_reset();
    step(1'b1, 6'd7, 1'b0, 1'b1, 32'h0000_001C);
    step(1'b1, 6'd7, 1'b0, 1'b0, 32'h0000_001C);
    check("idx7_low", 32'(b_predict), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    drive(1'b1, 6'd7, 1'b1, 1'b0, 32'h0000_001C);
    @(posedge clk_i);
    #1;
    rst_i    = 1'b0;
    update_i = 1'b0;
    check("rst_over_update_predict", 32'(b_predict), 32'd1);
    check("rst_over_update_branch", b_branch, 32'd0);
    check("rst_over_update_miss", b_miss, 32'd0);
    // Counter 7 back at INIT: one not-taken drops it below the MSB.
    step(1'b1, 6'd7, 1'b0, 1'b1, 32'h0000_001C);
    check("idx7_after_reset_dec", 32'(b_predict), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
